axis_lfsr_checker: RTL and testbench

//  - AXI4-Stream slave that receives a PRBS stream generated by the team's LFSR

---
 rtl/axis_lfsr_checker.sv | 112 +++++++++++
 tb/tb_axis_lfsr_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axis_lfsr_checker.sv
// AXI4-Stream PRBS checker: seeds on first beat, then predicts/compares every beat; status 1 cycle after beat, never back-pressures.
// Optional relock after RESYNC_THRESHOLD consecutive errors when LFSR_CHECKER_RESYNC_EN is defined.
module axis_lfsr_checker #(
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int CNTR_WIDTH       = 32,
  parameter int RESYNC_THRESHOLD = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        cfg_clear,
  output logic                        sts_locked,
  output logic [CNTR_WIDTH-1:0]       sts_words,
  output logic [CNTR_WIDTH-1:0]       sts_errors
);

  typedef enum logic {
    ST_SEED   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  if (AXIS_TDATA_WIDTH != 64 || RESYNC_THRESHOLD < 1 || RESYNC_THRESHOLD > 255) begin : g_bad_param
    $error("axis_lfsr_checker: unsupported parameter value");
  end

`ifdef LFSR_CHECKER_RESYNC_EN
  localparam logic [7:0] RESYNC_THR = 8'(RESYNC_THRESHOLD);
`endif

  function automatic logic [AXIS_TDATA_WIDTH-1:0] lfsr_step(input logic [AXIS_TDATA_WIDTH-1:0] x);
    return {x[62:0], x[62] ~^ x[61]};
  endfunction

  state_t                      state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0] expected_q, expected_d;
  logic [CNTR_WIDTH-1:0]       words_q, words_d;
  logic [CNTR_WIDTH-1:0]       errors_q, errors_d;
  logic [7:0]                  consec_q, consec_d;
  logic                        tready_q;
  logic                        beat;

  assign beat = s_axis_tvalid & tready_q;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    words_d    = words_q;
    errors_d   = errors_q;
    consec_d   = consec_q;
    if (cfg_clear) begin
      // Clear wins over a coincident beat: that beat is dropped entirely.
      state_d    = ST_SEED;
      expected_d = '0;
      words_d    = '0;
      errors_d   = '0;
      consec_d   = '0;
    end else if (beat) begin
      if (words_q != '1) begin
        words_d = words_q + CNTR_WIDTH'(1);
      end
      if (state_q == ST_SEED) begin
        expected_d = lfsr_step(s_axis_tdata);
        state_d    = ST_LOCKED;
      end else begin
        // Predict from our own state so a single corrupted word does not propagate.
        expected_d = lfsr_step(expected_q);
        if (s_axis_tdata == expected_q) begin
          consec_d = '0;
        end else begin
          if (errors_q != '1) begin
            errors_d = errors_q + CNTR_WIDTH'(1);
          end
          if (consec_q != 8'hFF) begin
            consec_d = consec_q + 8'd1;
          end
`ifdef LFSR_CHECKER_RESYNC_EN
          if (consec_d == RESYNC_THR) begin
            state_d  = ST_SEED;
            consec_d = '0;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_SEED;
      expected_q <= '0;
      words_q    <= '0;
      errors_q   <= '0;
      consec_q   <= '0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      words_q    <= words_d;
      errors_q   <= errors_d;
      consec_q   <= consec_d;
      tready_q   <= 1'b1;
    end
  end

  assign s_axis_tready = tready_q;
  assign sts_locked    = (state_q == ST_LOCKED);
  assign sts_words     = words_q;
  assign sts_errors    = errors_q;

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Self-checking bench for axis_lfsr_checker: vector table, long PRBS stream, relock and async reset sequences.
module tb_axis_lfsr_checker;

  logic        aclk;
  logic        aresetn;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        cfg_clear;
  logic        sts_locked;
  logic [31:0] sts_words;
  logic [31:0] sts_errors;

  axis_lfsr_checker #(
    .AXIS_TDATA_WIDTH(64),
    .CNTR_WIDTH(32),
    .RESYNC_THRESHOLD(8)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .cfg_clear(cfg_clear),
    .sts_locked(sts_locked),
    .sts_words(sts_words),
    .sts_errors(sts_errors)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        rdy;
    logic        lck;
    logic [31:0] w;
    logic [31:0] e;
  } exp_t;

  typedef struct {
    logic        vld;
    logic [63:0] dat;
    logic        clr;
    exp_t        ex;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] gen_step(input logic [63:0] x);
    logic fb;
    fb = ~(x[62] ^ x[61]);
    return (x << 1) | {63'd0, fb};
  endfunction

  function automatic exp_t mk(input logic r, input logic l, input logic [31:0] w, input logic [31:0] e);
    exp_t t;
    t.rdy = r; t.lck = l; t.w = w; t.e = e;
    return t;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input exp_t ex);
    check({nm, ".tready"}, {63'd0, s_axis_tready}, {63'd0, ex.rdy});
    check({nm, ".locked"}, {63'd0, sts_locked}, {63'd0, ex.lck});
    check({nm, ".words"}, {32'd0, sts_words}, {32'd0, ex.w});
    check({nm, ".errors"}, {32'd0, sts_errors}, {32'd0, ex.e});
  endtask

  // Drive one cycle; when chk is set the expectation goes through the scoreboard.
  task automatic cyc(input logic v, input logic [63:0] d, input logic c, input logic chk,
                     input exp_t ex, input string nm);
    exp_t got;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    cfg_clear     = c;
    if (chk) sb_q.push_back(ex);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    cfg_clear     = 1'b0;
    if (chk) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s: scoreboard empty", nm);
      end else begin
        got = sb_q.pop_front();
        check_all(nm, got);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t        tv[11];
  logic [63:0] g;
  logic [63:0] w;
  logic [63:0] sd;

  initial begin
    sd = 64'hDEAD_BEEF_0BAD_F00D;
    tv[0]  = '{1'b1, 64'h5555_5555_5555_5555, 1'b0, mk(1, 1, 1, 0)};
    tv[1]  = '{1'b0, 64'hFFFF_0000_FFFF_0000, 1'b0, mk(1, 1, 1, 0)};
    tv[2]  = '{1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, mk(1, 1, 2, 0)};
    tv[3]  = '{1'b1, 64'h5555_5555_5555_5554, 1'b0, mk(1, 1, 3, 0)};
    tv[4]  = '{1'b1, gen_step(64'h5555_5555_5555_5554) ^ 64'h8000_0000_0000_0000, 1'b0, mk(1, 1, 4, 1)};
    tv[5]  = '{1'b1, gen_step(gen_step(64'h5555_5555_5555_5554)), 1'b0, mk(1, 1, 5, 1)};
    tv[6]  = '{1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, mk(1, 0, 0, 0)};
    tv[7]  = '{1'b0, 64'h0, 1'b0, mk(1, 0, 0, 0)};
    tv[8]  = '{1'b1, sd, 1'b0, mk(1, 1, 1, 0)};
    tv[9]  = '{1'b0, 64'h0, 1'b0, mk(1, 1, 1, 0)};
    tv[10] = '{1'b1, gen_step(sd), 1'b0, mk(1, 1, 2, 0)};

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    cfg_clear     = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_all("in_reset", mk(0, 0, 0, 0));
    aresetn = 1'b1;
    cyc(0, 64'h0, 0, 1, mk(1, 0, 0, 0), "post_reset");

    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].vld, tv[i].dat, tv[i].clr, 1, tv[i].ex, $sformatf("vec%0d", i));
    end

    // 1000-word generator stream with word 500 corrupted
    cyc(0, 64'h0, 1, 1, mk(1, 0, 0, 0), "clear_before_stream");
    g = 64'h0123_4567_89AB_CDEF;
    for (int i = 1; i <= 1000; i++) begin
      w = (i == 500) ? (g ^ 64'h1) : g;
      if (i == 500)       cyc(1, w, 0, 1, mk(1, 1, 500, 1), "stream_w500");
      else if (i == 501)  cyc(1, w, 0, 1, mk(1, 1, 501, 1), "stream_w501");
      else if (i == 1000) cyc(1, w, 0, 1, mk(1, 1, 1000, 1), "stream_w1000");
      else                cyc(1, w, 0, 0, mk(0, 0, 0, 0), "");
      g = gen_step(g);
    end

    // Eight consecutive zero words after lock, then the stream resumes
    cyc(0, 64'h0, 1, 1, mk(1, 0, 0, 0), "clear_before_resync");
    g = 64'h0F0F_1234_AAAA_5A5A;
    cyc(1, g, 0, 1, mk(1, 1, 1, 0), "resync_seed");
    for (int i = 1; i <= 8; i++) begin
      g = gen_step(g);
      if (i == 7)      cyc(1, 64'h0, 0, 1, mk(1, 1, 8, 7), "resync_zero7");
`ifdef LFSR_CHECKER_RESYNC_EN
      else if (i == 8) cyc(1, 64'h0, 0, 1, mk(1, 0, 9, 8), "resync_zero8");
`else
      else if (i == 8) cyc(1, 64'h0, 0, 1, mk(1, 1, 9, 8), "resync_zero8");
`endif
      else             cyc(1, 64'h0, 0, 0, mk(0, 0, 0, 0), "");
    end
    for (int i = 0; i < 6; i++) begin
      g = gen_step(g);
      if (i == 0)      cyc(1, g, 0, 1, mk(1, 1, 10, 8), "relock_first");
      else if (i == 5) cyc(1, g, 0, 1, mk(1, 1, 15, 8), "relock_last");
      else             cyc(1, g, 0, 0, mk(0, 0, 0, 0), "");
    end

    // Asynchronous reset asserted between edges
    cyc(0, 64'h0, 1, 1, mk(1, 0, 0, 0), "clear_before_areset");
    g = 64'h7777_0000_1111_ABCD;
    cyc(1, g, 0, 0, mk(0, 0, 0, 0), "");
    g = gen_step(g);
    cyc(1, g, 0, 1, mk(1, 1, 2, 0), "pre_areset");
    #2;
    aresetn = 1'b0;
    #1;
    check_all("areset_async", mk(0, 0, 0, 0));
    #3;
    aresetn = 1'b1;
    cyc(1, 64'h1111_2222_3333_4444, 0, 1, mk(1, 0, 0, 0), "areset_release");
    g = 64'h4242_4242_0000_FFFF;
    cyc(1, g, 0, 1, mk(1, 1, 1, 0), "areset_reseed");
    g = gen_step(g);
    cyc(1, g, 0, 1, mk(1, 1, 2, 0), "areset_relocked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
